bram_port_arb: RTL
==================

Name: bram_port_arb

Overview:
- Shares one dpbram port between two requesters, e.g. the conv engine (requester 0) and a DMA/debug reader (requester 1).
- Each requester holds a single-beat read and/or write request until granted. The arbiter drives the BRAM port from registered command signals.
- Read data is routed back to the requester that issued the read, using a latency-matched tag pipeline.
- Arbitration is round-robin with a bounded burst lock, so streaming accesses stay contiguous without starving the other side.

Parameters:
- ADDR_BW, 32, BRAM address width.
- DATA_BW, 32, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles, from a registered o_r_en to a valid i_r_data. Legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits. Legal range 1..255.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- i_w_en_0  in  1  requester 0 write request.
- i_w_addr_0  in  ADDR_BW  requester 0 write address.
- i_w_data_0  in  DATA_BW  requester 0 write data.
- i_r_en_0  in  1  requester 0 read request.
- i_r_addr_0  in  ADDR_BW  requester 0 read address.
- o_gnt_0  out  1  requester 0 beat accepted this cycle.
- o_r_data_0  out  DATA_BW  requester 0 read data.
- o_r_valid_0  out  1  requester 0 read data valid (1-cycle pulse).
- i_w_en_1, i_w_addr_1, i_w_data_1, i_r_en_1, i_r_addr_1, o_gnt_1, o_r_data_1, o_r_valid_1: same as requester 0, for requester 1.
- o_w_en  out  1  BRAM write enable.
- o_w_addr  out  ADDR_BW  BRAM write address.
- o_w_data  out  DATA_BW  BRAM write data.
- o_r_en  out  1  BRAM read enable.
- o_r_addr  out  ADDR_BW  BRAM read address.
- i_r_data  in  DATA_BW  BRAM read data.

Behaviour:
- Clock and reset: one clock, ACLK. ARESETn is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - last_owner = 1, so requester 0 wins the first tie.
  - burst_cnt = 0.
  - The tag pipeline is cleared.
- Request: req_x = i_w_en_x | i_r_en_x. A requester holds its enables, addresses and data stable until it sees o_gnt_x high at a rising edge.
- One grant per cycle. The beat may carry a read and a write together; both are forwarded in the same BRAM cycle.
- Grant decision (combinational from requests and state; o_gnt_x is never registered):
  - Only one req_x set -> grant x.
  - Both set, owner active with burst_cnt < MAX_BURST -> grant owner.
  - Both set, otherwise -> grant !last_owner.
  - Neither set -> no grant; burst_cnt is kept.
- Burst counter, on each grant:
  - Same owner as last_owner -> burst_cnt increments, saturating at MAX_BURST.
  - Owner change -> burst_cnt = 1, last_owner = x.
- Idle cycles do not reset burst_cnt. A requester that is alone is never throttled.
- Command register, updated every cycle:
  - On grant: o_w_en/o_w_addr/o_w_data and o_r_en/o_r_addr load from the granted requester, one cycle after the grant.
  - No grant: o_w_en = o_r_en = 0. Addresses and data hold.
- Read return, via a tag pipeline of RD_LAT stages carrying {valid, id}:
  - Stage 0 loads {o_r_en, owner} alongside the command register.
  - At the tail, when valid is set: o_r_valid_id pulses for one cycle and o_r_data_id = i_r_data, registered.
  - Total latency from o_gnt_x to o_r_valid_x = RD_LAT + 2 cycles.
  - o_r_data_x holds its last value when o_r_valid_x is 0.
- Ordering: return order equals grant order. Back-to-back reads are fully pipelined at one per cycle.
- Write-only beats produce no o_r_valid.
- Reset mid-operation: in-flight tags are discarded; no o_r_valid is emitted after ARESETn is released for reads granted before reset.
- Requests dropped without a grant are ignored. This is a protocol error for the requester and is not checked.

Test Plan:
- Reset, then requester 0 alone writes addr 0x10 data 0xA5A5A5A5 -> o_gnt_0 in the same cycle; next cycle o_w_en=1, o_w_addr=0x10, o_w_data=0xA5A5A5A5; o_gnt_1 stays 0.
- Requester 1 alone reads addr 0x10, BRAM model returning 0xA5A5A5A5 with RD_LAT=1 -> o_r_valid_1 pulses exactly 3 cycles after o_gnt_1, o_r_data_1=0xA5A5A5A5, o_r_valid_0 stays 0.
- Both requesters read continuously for 20 cycles with MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0…; each o_r_valid_x count equals its grant count; data matches the per-address model.
- Both request in the first cycle after reset with MAX_BURST=1 -> grants strictly alternate 0,1,0,1 starting with 0.
- Requester 0 read plus write in one beat (read addr 3, write addr 7) -> a single grant; o_r_en and o_w_en both high in the same cycle; one o_r_valid_0 follows.
- Reads granted, then ARESETn asserted for 2 cycles before return -> all outputs 0 during reset; no o_r_valid_x after release; the next request is served normally, with requester 0 winning the tie.

Source files
------------

// File: rtl/bram_port_arb.sv
// Two-requester arbiter for a single BRAM port: round-robin with a bounded burst lock.
// Read data is steered back to its issuer through a tag pipeline matched to the BRAM read latency.
module bram_port_arb #(
    parameter int ADDR_BW   = 32,
    parameter int DATA_BW   = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               i_w_en_0,
    input  logic [ADDR_BW-1:0] i_w_addr_0,
    input  logic [DATA_BW-1:0] i_w_data_0,
    input  logic               i_r_en_0,
    input  logic [ADDR_BW-1:0] i_r_addr_0,
    output logic               o_gnt_0,
    output logic [DATA_BW-1:0] o_r_data_0,
    output logic               o_r_valid_0,
    input  logic               i_w_en_1,
    input  logic [ADDR_BW-1:0] i_w_addr_1,
    input  logic [DATA_BW-1:0] i_w_data_1,
    input  logic               i_r_en_1,
    input  logic [ADDR_BW-1:0] i_r_addr_1,
    output logic               o_gnt_1,
    output logic [DATA_BW-1:0] o_r_data_1,
    output logic               o_r_valid_1,
    output logic               o_w_en,
    output logic [ADDR_BW-1:0] o_w_addr,
    output logic [DATA_BW-1:0] o_w_data,
    output logic               o_r_en,
    output logic [ADDR_BW-1:0] o_r_addr,
    input  logic [DATA_BW-1:0] i_r_data
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    logic               w_req_0;
    logic               w_req_1;
    logic               w_keep;
    logic               w_gnt_0;
    logic               w_gnt_1;
    logic               w_any;
    logic               w_owner;
    logic               w_sel_w_en;
    logic               w_sel_r_en;
    logic [ADDR_BW-1:0] w_sel_w_addr;
    logic [ADDR_BW-1:0] w_sel_r_addr;
    logic [DATA_BW-1:0] w_sel_w_data;

    logic               r_last_owner;
    logic [7:0]         r_burst_cnt;
    logic               r_w_en;
    logic [ADDR_BW-1:0] r_w_addr;
    logic [DATA_BW-1:0] r_w_data;
    logic               r_r_en;
    logic [ADDR_BW-1:0] r_r_addr;
    logic [RD_LAT:0]    r_tag_vld;
    logic [RD_LAT:0]    r_tag_id;
    logic               r_r_valid_0;
    logic               r_r_valid_1;
    logic [DATA_BW-1:0] r_r_data_0;
    logic [DATA_BW-1:0] r_r_data_1;

    // Request decode; a zero burst count means no owner has been granted since reset
    always_comb begin
        w_req_0 = i_w_en_0 | i_r_en_0;
        w_req_1 = i_w_en_1 | i_r_en_1;
        w_keep  = (r_burst_cnt != 8'd0) && (r_burst_cnt < MAX_CNT);
    end

    // Grant decision
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        if (w_req_0 && w_req_1) begin
            if (w_keep) begin
                w_gnt_0 = ~r_last_owner;
                w_gnt_1 = r_last_owner;
            end else begin
                w_gnt_0 = r_last_owner;
                w_gnt_1 = ~r_last_owner;
            end
        end else if (w_req_0) begin
            w_gnt_0 = 1'b1;
        end else if (w_req_1) begin
            w_gnt_1 = 1'b1;
        end else begin
            w_gnt_0 = 1'b0;
            w_gnt_1 = 1'b0;
        end
        w_any   = w_gnt_0 | w_gnt_1;
        w_owner = w_gnt_1;
    end

    // Beat selection from the granted requester
    always_comb begin
        if (w_owner) begin
            w_sel_w_en   = i_w_en_1;
            w_sel_w_addr = i_w_addr_1;
            w_sel_w_data = i_w_data_1;
            w_sel_r_en   = i_r_en_1;
            w_sel_r_addr = i_r_addr_1;
        end else begin
            w_sel_w_en   = i_w_en_0;
            w_sel_w_addr = i_w_addr_0;
            w_sel_w_data = i_w_data_0;
            w_sel_r_en   = i_r_en_0;
            w_sel_r_addr = i_r_addr_0;
        end
    end

    // Burst lock state: owner and saturating run length
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 8'd0;
        end else if (w_any) begin
            if (w_owner == r_last_owner) begin
                if (r_burst_cnt < MAX_CNT) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end else begin
                    r_burst_cnt <= MAX_CNT;
                end
            end else begin
                r_burst_cnt  <= 8'd1;
                r_last_owner <= w_owner;
            end
        end
    end

    // BRAM command register; addresses and data hold when idle
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
            r_r_en   <= 1'b0;
            r_r_addr <= '0;
        end else begin
            r_w_en <= w_any & w_sel_w_en;
            r_r_en <= w_any & w_sel_r_en;
            if (w_any) begin
                r_w_addr <= w_sel_w_addr;
                r_w_data <= w_sel_w_data;
                r_r_addr <= w_sel_r_addr;
            end
        end
    end

    // Tag pipeline (stage 0 mirrors o_r_en, RD_LAT more stages span the BRAM) and read return
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_tag_vld   <= '0;
            r_tag_id    <= '0;
            r_r_valid_0 <= 1'b0;
            r_r_valid_1 <= 1'b0;
            r_r_data_0  <= '0;
            r_r_data_1  <= '0;
        end else begin
            r_tag_vld   <= {r_tag_vld[RD_LAT-1:0], w_any & w_sel_r_en};
            r_tag_id    <= {r_tag_id[RD_LAT-1:0], w_owner};
            r_r_valid_0 <= r_tag_vld[RD_LAT] & ~r_tag_id[RD_LAT];
            r_r_valid_1 <= r_tag_vld[RD_LAT] & r_tag_id[RD_LAT];
            if (r_tag_vld[RD_LAT] && !r_tag_id[RD_LAT]) begin
                r_r_data_0 <= i_r_data;
            end
            if (r_tag_vld[RD_LAT] && r_tag_id[RD_LAT]) begin
                r_r_data_1 <= i_r_data;
            end
        end
    end

    assign o_gnt_0     = w_gnt_0 & ARESETn;
    assign o_gnt_1     = w_gnt_1 & ARESETn;
    assign o_w_en      = r_w_en;
    assign o_w_addr    = r_w_addr;
    assign o_w_data    = r_w_data;
    assign o_r_en      = r_r_en;
    assign o_r_addr    = r_r_addr;
    assign o_r_valid_0 = r_r_valid_0;
    assign o_r_valid_1 = r_r_valid_1;
    assign o_r_data_0  = r_r_data_0;
    assign o_r_data_1  = r_r_data_1;

endmodule
